regfile_mp: RTL and testbench

//  Parametrised multi-port CPU register file: NUM_RD async read ports, 2 write ports, optional hardwired-zero r0.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_clr_fsm.sv | 66 ++++++
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between issue/write-back logic (master) and the register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3
);
  localparam int AW = rf_aw(NUM_REGS);

  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [1:0]              wr_en;
  logic [2*AW-1:0]         wr_addr;
  logic [2*WIDTH-1:0]      wr_data;
  logic                    wr_ready;
  logic                    sb_set_en;
  logic [AW-1:0]           sb_set_addr;
  logic [NUM_REGS-1:0]     sb_busy;
  logic                    clr_req;
  logic                    clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
    input  rd_data, wr_ready, sb_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
    output rd_data, wr_ready, sb_busy, clr_busy
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks idx over every register once, then releases the write path.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int AW = rf_aw(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          wr_ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // idx stops on the compare with the last register, so a clear is exactly one pass
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_busy  = 1'b0;
    wr_ready  = 1'b1;
    clr_we    = 1'b0;
    clr_done  = 1'b0;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          idx_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        clr_busy = 1'b1;
        wr_ready = 1'b0;
        clr_we   = 1'b1;
        if (idx == LAST_IDX) begin
          clr_done  = 1'b1;
          state_nxt = RF_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  assign clr_idx = idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads with optional bypass, two write ports,
// issue scoreboard and a bulk-clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [AW-1:0]    wa   [2];
  logic [WIDTH-1:0] wd   [2];
  logic [1:0]       we;
  logic             sb_set;
  logic [AW-1:0]    ra   [NUM_RD];
  logic [WIDTH-1:0] rv   [NUM_RD];
  logic             clr_we;
  logic             clr_done;
  logic [AW-1:0]    clr_idx;

  regfile_clr_fsm #(.NUM_REGS(NUM_REGS)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .clr_busy (bus.clr_busy),
    .wr_ready (bus.wr_ready),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .clr_done (clr_done)
  );

  // Accepted writes: only while the sequencer is idle, never to a hardwired r0
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa[p] = bus.wr_addr[p*AW +: AW];
      wd[p] = bus.wr_data[p*WIDTH +: WIDTH];
      we[p] = bus.wr_en[p] && bus.wr_ready && !(ZERO_REG != 0 && wa[p] == '0);
    end
    sb_set = bus.sb_set_en && !bus.clr_busy && !(ZERO_REG != 0 && bus.sb_set_addr == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (clr_we) begin
      regs[clr_idx] <= '0;
    end else begin
      if (we[0] && !(we[1] && wa[1] == wa[0])) regs[wa[0]] <= wd[0];
      if (we[1]) regs[wa[1]] <= wd[1];
    end
  end

  // Port 1 is checked last so it wins the bypass just as it wins the collision
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = bus.rd_addr[i*AW +: AW];
      rv[i] = regs[ra[i]];
      if (BYPASS != 0) begin
        if (we[0] && wa[0] == ra[i]) rv[i] = wd[0];
        if (we[1] && wa[1] == ra[i]) rv[i] = wd[1];
      end
      if (ZERO_REG != 0 && ra[i] == '0) rv[i] = '0;
      bus.rd_data[i*WIDTH +: WIDTH] = rv[i];
    end
  end

  // A new producer issued in the same cycle as a write-back keeps the register busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sb_busy <= '0;
    end else if (clr_done) begin
      bus.sb_busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (sb_set && bus.sb_set_addr == AW'(r))
          bus.sb_busy[r] <= 1'b1;
        else if ((we[0] && wa[0] == AW'(r)) || (we[1] && wa[1] == AW'(r)))
          bus.sb_busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 8;
  localparam int NUM_RD   = 3;
  localparam int AW       = rf_aw(NUM_REGS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();
  regfile_mp_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus_nb ();

  regfile_mp #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  regfile_mp #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(0))
    dut_nb (.clk(clk), .rst(rst), .bus(bus_nb.slave));

  assign bus_nb.rd_addr     = bus.rd_addr;
  assign bus_nb.wr_en       = bus.wr_en;
  assign bus_nb.wr_addr     = bus.wr_addr;
  assign bus_nb.wr_data     = bus.wr_data;
  assign bus_nb.sb_set_en   = bus.sb_set_en;
  assign bus_nb.sb_set_addr = bus.sb_set_addr;
  assign bus_nb.clr_req     = bus.clr_req;

  typedef struct {
    string                   tag;
    logic [NUM_RD*WIDTH-1:0] rd;
    logic [NUM_RD*WIDTH-1:0] rd_nb;
    logic [NUM_REGS-1:0]     busy;
    logic                    clr_busy;
    logic                    wr_ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Stimulus for the current cycle
  logic [1:0]       s_we;
  int               s_wa [2];
  logic [WIDTH-1:0] s_wd [2];
  logic             s_set;
  int               s_saddr;
  logic             s_creq;
  int               s_ra [NUM_RD];

  // Reference model: architectural contents plus remaining clear cycles
  logic [WIDTH-1:0]    m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;
  int                  m_clr_left;

  task automatic idle();
    s_we = 2'b00; s_wa = '{0, 0}; s_wd = '{16'h0, 16'h0};
    s_set = 1'b0; s_saddr = 0; s_creq = 1'b0;
    for (int i = 0; i < NUM_RD; i++) s_ra[i] = 0;
  endtask

  task automatic randomStim(input int creq_odds);
    s_we = 2'($urandom_range(0, 3));
    for (int p = 0; p < 2; p++) begin
      s_wa[p] = $urandom_range(0, NUM_REGS - 1);
      s_wd[p] = WIDTH'($urandom);
    end
    s_set   = 1'($urandom_range(0, 1));
    s_saddr = $urandom_range(0, NUM_REGS - 1);
    s_creq  = ($urandom_range(1, creq_odds) == 1);
    for (int i = 0; i < NUM_RD; i++) s_ra[i] = $urandom_range(0, NUM_REGS - 1);
  endtask

  task automatic driveBus();
    bus.wr_en       = s_we;
    bus.wr_addr     = {AW'(s_wa[1]), AW'(s_wa[0])};
    bus.wr_data     = {s_wd[1], s_wd[0]};
    bus.sb_set_en   = s_set;
    bus.sb_set_addr = AW'(s_saddr);
    bus.clr_req     = s_creq;
    for (int i = 0; i < NUM_RD; i++) bus.rd_addr[i*AW +: AW] = AW'(s_ra[i]);
  endtask

  function automatic logic [WIDTH-1:0] modelRead(input int a, input bit bypass);
    logic [WIDTH-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (bypass && m_clr_left == 0) begin
      if (s_we[0] && s_wa[0] == a) v = s_wd[0];
      if (s_we[1] && s_wa[1] == a) v = s_wd[1];
    end
    return v;
  endfunction

  task automatic pushExpected(input string tag);
    exp_t e;
    e.tag = tag;
    for (int i = 0; i < NUM_RD; i++) begin
      e.rd[i*WIDTH +: WIDTH]    = modelRead(s_ra[i], 1'b1);
      e.rd_nb[i*WIDTH +: WIDTH] = modelRead(s_ra[i], 1'b0);
    end
    e.busy     = m_busy;
    e.clr_busy = (m_clr_left != 0);
    e.wr_ready = (m_clr_left == 0);
    exp_q.push_back(e);
  endtask

  task automatic modelEdge();
    if (m_clr_left != 0) begin
      m_regs[NUM_REGS - m_clr_left] = '0;
      m_clr_left--;
      if (m_clr_left == 0) m_busy = '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (s_we[p] && s_wa[p] != 0) begin
          m_regs[s_wa[p]] = s_wd[p];
          m_busy[s_wa[p]] = 1'b0;
        end
      if (s_set && s_saddr != 0) m_busy[s_saddr] = 1'b1;
      if (s_creq) m_clr_left = NUM_REGS;
    end
  endtask

  task automatic applyStimulus(input string tag);
    driveBus();
    pushExpected(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Reset lands mid-cycle so the outputs must clear without any clock edge
  task automatic applyReset(input string tag);
    idle();
    for (int i = 0; i < NUM_RD; i++) s_ra[i] = 3;
    driveBus();
    rst = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
    m_busy     = '0;
    m_clr_left = 0;
    pushExpected(tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField({e.tag, "/rd_data"},    64'(bus.rd_data),    64'(e.rd));
    checkField({e.tag, "/rd_data_nb"}, 64'(bus_nb.rd_data), 64'(e.rd_nb));
    checkField({e.tag, "/sb_busy"},    64'(bus.sb_busy),    64'(e.busy));
    checkField({e.tag, "/clr_busy"},   64'(bus.clr_busy),   64'(e.clr_busy));
    checkField({e.tag, "/wr_ready"},   64'(bus.wr_ready),   64'(e.wr_ready));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    idle();
    applyReset("reset_init");

    idle(); s_we = 2'b01; s_wa[0] = 3; s_wd[0] = 16'h1234; s_ra[0] = 3;
    applyStimulus("write_r3");
    idle(); s_ra = '{3, 3, 3};
    applyStimulus("read_r3");
    applyReset("async_reset");

    idle(); s_we = 2'b11; s_wa = '{5, 5}; s_wd[0] = 16'hAAAA; s_wd[1] = 16'h5555; s_ra[0] = 5;
    applyStimulus("collision_wr");
    idle(); s_ra = '{5, 5, 0};
    applyStimulus("collision_rd");

    idle(); s_we = 2'b01; s_wa[0] = 2; s_wd[0] = 16'h00FF; s_ra[0] = 2;
    applyStimulus("bypass");

    idle(); s_we = 2'b01; s_wa[0] = 0; s_wd[0] = 16'hBEEF; s_set = 1'b1; s_saddr = 0;
    applyStimulus("zero_wr");
    idle();
    applyStimulus("zero_rd");

    idle(); s_set = 1'b1; s_saddr = 4;
    applyStimulus("sb_set");
    idle(); s_set = 1'b1; s_saddr = 4; s_we = 2'b10; s_wa[1] = 4; s_wd[1] = 16'h4444;
    applyStimulus("sb_set_and_wr");
    idle(); s_we = 2'b01; s_wa[0] = 4; s_wd[0] = 16'h4445; s_ra[0] = 4;
    applyStimulus("sb_wr_alone");
    idle(); s_ra[0] = 4;
    applyStimulus("sb_cleared");

    for (int r = 1; r < NUM_REGS; r++) begin
      idle(); s_we = 2'b01; s_wa[0] = r; s_wd[0] = WIDTH'($urandom);
      s_set = 1'b1; s_saddr = r; s_ra = '{r, NUM_REGS - r, 1};
      applyStimulus("fill");
    end
    idle(); s_creq = 1'b1; s_ra = '{1, 2, 7};
    applyStimulus("clr_req");
    for (int k = 0; k < NUM_REGS; k++) begin
      randomStim(1);
      applyStimulus("clearing");
    end
    idle(); s_ra = '{1, 5, 7};
    applyStimulus("after_clear");

    for (int n = 0; n < 400; n++) begin
      randomStim(30);
      applyStimulus("random");
    end

    for (int k = 0; k < NUM_REGS + 1; k++) begin
      idle(); applyStimulus("drain");
    end
    idle(); s_we = 2'b10; s_wa[1] = 6; s_wd[1] = 16'h6666;
    applyStimulus("pre_clear_wr");
    idle(); s_creq = 1'b1;
    applyStimulus("clr_req2");
    for (int k = 0; k < 3; k++) begin
      randomStim(2);
      applyStimulus("clearing2");
    end
    applyReset("reset_mid_clear");
    idle(); s_we = 2'b01; s_wa[0] = 6; s_wd[0] = 16'h0606; s_ra = '{6, 6, 6};
    applyStimulus("post_reset_wr");
    idle(); s_ra = '{6, 7, 0};
    applyStimulus("post_reset_rd");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
